array_cmd_sequencer: RTL
========================

// Module: array_cmd_sequencer
// PURPOSE
//  Synthesisable, parametrised command generator for the CIM array: on start, walks a
//  programmed sequence of WRITE sweeps (all banks x rows), a MAC row burst and a CAM lookup.
//  Drives the array's op_code/addr/data_bank/data_in bus with a valid/ready handshake.
//  Sits between the host/config regs and the array; replaces hand-sequenced bench stimulus.
// PARAMETERS
//  NUM_BANKS 16  banks in array; BANK_AW = $clog2(NUM_BANKS)
//  NUM_ROWS  4   rows per bank; ROW_AW = $clog2(NUM_ROWS)
//  COL_AW    3   column field width in addr; always driven 0
//  DW        16  data_bank / data_in width
// PORTS
//  clk        in  1        clock, rising edge
//  rst_n      in  1        asynchronous active-low reset
//  start      in  1        launch sequence; sampled only in IDLE
//  abort      in  1        synchronous abort; wins over every other event
//  en_write   in  1        include WRITE sweep phase
//  en_mac     in  1        include MAC burst phase
//  en_cam     in  1        include CAM phase
//  seed       in  DW       WRITE pattern offset
//  mac_vec    in  DW       data_in for every MAC command
//  cam_key    in  DW       data_bank for the CAM command
//  cam_vec    in  DW       data_in for the CAM command
//  cmd_ready  in  1        array accepts current command
//  cmd_valid  out 1        command on bus is valid
//  op_code    out 2        00 MAC, 01 WRITE, 10 CAM, 11 IDLE
//  addr       out BANK_AW+ROW_AW+COL_AW  {bank,row,col}
//  data_bank  out DW       weight / CAM key
//  data_in    out DW       input vector
//  busy       out 1        high from cycle after start until done
//  done       out 1        one-cycle completion pulse
// BEHAVIOUR
//  Reset: cmd_valid=0, op_code=11, addr=0, data_bank=0, data_in=0, busy=0, done=0; state IDLE.
//  All outputs registered. Transfer = cmd_valid & cmd_ready at rising edge.
//  While cmd_valid & !cmd_ready: op_code/addr/data_* held stable (no change allowed).
//  cmd_valid=0 => op_code=11, addr/data hold last value.
//  FSM: IDLE -> WRITE -> MAC -> CAM -> DONE -> IDLE; disabled phases skipped in order.
//   IDLE: start=1 -> first enabled phase, first command valid next cycle (latency 1);
//         no phase enabled -> DONE (done pulses cycle N+2, no commands issued).
//   WRITE: bank-major, row-minor sweep b=0..NUM_BANKS-1, r=0..NUM_ROWS-1;
//         addr={b,r,0}, data_bank=(seed+b+r) mod 2^DW, data_in=0. NUM_BANKS*NUM_ROWS cmds.
//   MAC: r=0..NUM_ROWS-1, addr={0,r,0}, data_bank=0, data_in=mac_vec. NUM_ROWS cmds.
//   CAM: one cmd, addr=0, data_bank=cam_key, data_in=cam_vec.
//   Next command presented the cycle after the accepting edge (back-to-back at full ready).
//   Phase advance on acceptance of its last command (row wrap to 0 + bank at max).
//   DONE: cmd_valid=0, done=1 for exactly one cycle, busy=0, return IDLE.
//  start while busy: ignored. en_*/seed/mac_vec/cam_* sampled at start, held internally.
//  abort (any state): next cycle IDLE, cmd_valid=0, op_code=11, busy=0, no done pulse;
//   an in-flight command accepted on the same edge as abort is still counted as issued.
//  rst_n low mid-sequence: immediate return to reset values, counters cleared.
//  Counter wrap: row counter wraps NUM_ROWS-1 -> 0 carrying into bank; non-power-of-2 ok.
// STRUCTURE
//  Package cella_array_pkg: OP_MAC/OP_WRITE/OP_CAM/OP_IDLE codes, seq state enum
//   (S_IDLE,S_WRITE,S_MAC,S_CAM,S_DONE), addr field-packing function.
//  Sub-module cella_addr_counter: bank/row counter with inc, clr, wrap and last flags.
// TESTING
//  1 Defaults, all en=1, seed=0, ready=1: 64 WRITEs, bank5 row3 -> data_bank=0x0008;
//    then 4 MACs data_in=mac_vec; 1 CAM; done one cycle after CAM accept; total 69 cmds.
//  2 ready toggled random 50%: bus never changes while valid&!ready; same 69-cmd trace.
//  3 seed=0xFFFE, en_write only: bank0 row0=0xFFFE, bank0 row2=0x0000 (wrap), then done.
//  4 en_*=0, start: no cmd_valid, done pulse exactly cycle start+2.
//  5 abort during WRITE at bank3: next cycle valid=0, op=11, busy=0, no done; restart ok.
//  6 rst_n low during MAC: all outputs at reset values asynchronously; NUM_BANKS=12,
//    NUM_ROWS=3 build: 36 WRITEs, last addr {11,2,0}.

Source files
------------

// File: rtl/cella_array_pkg.sv
// Shared definitions for the CIM array command path: op codes, sequencer states
// and the {bank,row,col} address packing used on the array bus.
package cella_array_pkg;

  localparam logic [1:0] OP_MAC   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CAM   = 2'b10;
  localparam logic [1:0] OP_IDLE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_MAC   = 3'd2,
    S_CAM   = 3'd3,
    S_DONE  = 3'd4
  } seq_state_e;

  // Column field is always zero; callers size-cast the result to their bus width.
  function automatic logic [31:0] pack_addr(input logic [31:0] bank, input logic [31:0] row,
                                            input int row_aw, input int col_aw);
    return (bank << (row_aw + col_aw)) | (row << col_aw);
  endfunction

endpackage

// File: rtl/cella_addr_counter.sv
// Bank-major / row-minor position counter. Exposes the position after an
// increment so the sequencer can register the next command in the same cycle.
module cella_addr_counter #(
  parameter int NUM_BANKS = 16,
  parameter int NUM_ROWS  = 4,
  parameter int BANK_AW   = 4,
  parameter int ROW_AW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               inc_i,
  output logic [BANK_AW-1:0] bank_nxt_o,
  output logic [ROW_AW-1:0]  row_nxt_o,
  output logic               row_last_o,
  output logic               last_o
);

  localparam logic [BANK_AW-1:0] BANK_MAX = BANK_AW'(NUM_BANKS - 1);
  localparam logic [ROW_AW-1:0]  ROW_MAX  = ROW_AW'(NUM_ROWS - 1);

  logic [BANK_AW-1:0] bank_q, bank_d;
  logic [ROW_AW-1:0]  row_q, row_d;
  logic               bank_last_s;

  // Row wraps at NUM_ROWS-1 (not at a power of two) and carries into the bank.
  always_comb begin
    bank_last_s = (bank_q == BANK_MAX);
    row_last_o  = (row_q == ROW_MAX);
    last_o      = bank_last_s & row_last_o;
    if (row_last_o) begin
      row_nxt_o  = '0;
      bank_nxt_o = bank_last_s ? '0 : bank_q + BANK_AW'(1);
    end else begin
      row_nxt_o  = row_q + ROW_AW'(1);
      bank_nxt_o = bank_q;
    end
  end

  always_comb begin
    if (clr_i) begin
      bank_d = '0;
      row_d  = '0;
    end else if (inc_i) begin
      bank_d = bank_nxt_o;
      row_d  = row_nxt_o;
    end else begin
      bank_d = bank_q;
      row_d  = row_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q <= '0;
      row_q  <= '0;
    end else begin
      bank_q <= bank_d;
      row_q  <= row_d;
    end
  end

endmodule

// File: rtl/array_cmd_sequencer.sv
// Command generator for the CIM array: on start walks the enabled WRITE sweep,
// MAC row burst and CAM lookup, driving a registered valid/ready command bus.
module array_cmd_sequencer
  import cella_array_pkg::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int NUM_ROWS  = 4,
  parameter int COL_AW    = 3,
  parameter int DW        = 16,
  localparam int BANK_AW  = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
  localparam int ROW_AW   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
  localparam int ADDR_W   = BANK_AW + ROW_AW + COL_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              en_write,
  input  logic              en_mac,
  input  logic              en_cam,
  input  logic [DW-1:0]     seed,
  input  logic [DW-1:0]     mac_vec,
  input  logic [DW-1:0]     cam_key,
  input  logic [DW-1:0]     cam_vec,
  input  logic              cmd_ready,
  output logic              cmd_valid,
  output logic [1:0]        op_code,
  output logic [ADDR_W-1:0] addr,
  output logic [DW-1:0]     data_bank,
  output logic [DW-1:0]     data_in,
  output logic              busy,
  output logic              done
);

  seq_state_e        state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic [1:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DW-1:0]     data_bank_q, data_bank_d;
  logic [DW-1:0]     data_in_q, data_in_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              en_mac_q, en_cam_q;
  logic [DW-1:0]     seed_q, mac_vec_q, cam_key_q, cam_vec_q;
  logic [DW-1:0]     seed_s, mac_vec_s, cam_key_s, cam_vec_s;

  logic              xfer_s, load_s, cfg_load_s, cnt_clr_s, cnt_inc_s;
  seq_state_e        first_s, after_write_s, after_mac_s, tgt_s;
  logic [BANK_AW-1:0] bank_nxt_s, pos_bank_s;
  logic [ROW_AW-1:0]  row_nxt_s, pos_row_s;
  logic              row_last_s, last_s;

  logic              img_valid_s;
  logic [1:0]        img_op_s;
  logic [ADDR_W-1:0] img_addr_s;
  logic [DW-1:0]     img_bank_s, img_in_s;

  cella_addr_counter #(
    .NUM_BANKS(NUM_BANKS),
    .NUM_ROWS (NUM_ROWS),
    .BANK_AW  (BANK_AW),
    .ROW_AW   (ROW_AW)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (cnt_clr_s),
    .inc_i     (cnt_inc_s),
    .bank_nxt_o(bank_nxt_s),
    .row_nxt_o (row_nxt_s),
    .row_last_o(row_last_s),
    .last_o    (last_s)
  );

  assign xfer_s = cmd_valid_q & cmd_ready;

  // The first command is built from live inputs since config is captured on that same edge.
  always_comb begin
    if (state_q == S_IDLE) begin
      seed_s    = seed;
      mac_vec_s = mac_vec;
      cam_key_s = cam_key;
      cam_vec_s = cam_vec;
    end else begin
      seed_s    = seed_q;
      mac_vec_s = mac_vec_q;
      cam_key_s = cam_key_q;
      cam_vec_s = cam_vec_q;
    end
  end

  always_comb begin
    if (en_write)      first_s = S_WRITE;
    else if (en_mac)   first_s = S_MAC;
    else if (en_cam)   first_s = S_CAM;
    else               first_s = S_DONE;
    if (en_mac_q)      after_write_s = S_MAC;
    else if (en_cam_q) after_write_s = S_CAM;
    else               after_write_s = S_DONE;
    if (en_cam_q)      after_mac_s = S_CAM;
    else               after_mac_s = S_DONE;
  end

  always_comb begin
    state_d    = state_q;
    tgt_s      = S_IDLE;
    pos_bank_s = '0;
    pos_row_s  = '0;
    load_s     = 1'b0;
    cfg_load_s = 1'b0;
    cnt_clr_s  = 1'b0;
    cnt_inc_s  = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
    if (abort) begin
      state_d   = S_IDLE;
      cnt_clr_s = 1'b1;
      busy_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cfg_load_s = 1'b1;
            cnt_clr_s  = 1'b1;
            busy_d     = 1'b1;
            load_s     = 1'b1;
            state_d    = first_s;
            tgt_s      = first_s;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WRITE: begin
          if (xfer_s && last_s) begin
            load_s    = 1'b1;
            cnt_clr_s = 1'b1;
            state_d   = after_write_s;
            tgt_s     = after_write_s;
          end else if (xfer_s) begin
            load_s     = 1'b1;
            cnt_inc_s  = 1'b1;
            tgt_s      = S_WRITE;
            pos_bank_s = bank_nxt_s;
            pos_row_s  = row_nxt_s;
          end else begin
            state_d = S_WRITE;
          end
        end
        S_MAC: begin
          if (xfer_s && row_last_s) begin
            load_s    = 1'b1;
            cnt_clr_s = 1'b1;
            state_d   = after_mac_s;
            tgt_s     = after_mac_s;
          end else if (xfer_s) begin
            load_s    = 1'b1;
            cnt_inc_s = 1'b1;
            tgt_s     = S_MAC;
            pos_row_s = row_nxt_s;
          end else begin
            state_d = S_MAC;
          end
        end
        S_CAM: begin
          if (xfer_s) begin
            load_s  = 1'b1;
            state_d = S_DONE;
            tgt_s   = S_DONE;
          end else begin
            state_d = S_CAM;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  // Command image for the phase being entered or continued; non-command targets idle the bus.
  always_comb begin
    img_valid_s = 1'b0;
    img_op_s    = OP_IDLE;
    img_addr_s  = addr_q;
    img_bank_s  = data_bank_q;
    img_in_s    = data_in_q;
    case (tgt_s)
      S_WRITE: begin
        img_valid_s = 1'b1;
        img_op_s    = OP_WRITE;
        img_addr_s  = ADDR_W'(pack_addr(32'(pos_bank_s), 32'(pos_row_s), ROW_AW, COL_AW));
        img_bank_s  = seed_s + DW'(pos_bank_s) + DW'(pos_row_s);
        img_in_s    = '0;
      end
      S_MAC: begin
        img_valid_s = 1'b1;
        img_op_s    = OP_MAC;
        img_addr_s  = ADDR_W'(pack_addr(32'd0, 32'(pos_row_s), ROW_AW, COL_AW));
        img_bank_s  = '0;
        img_in_s    = mac_vec_s;
      end
      S_CAM: begin
        img_valid_s = 1'b1;
        img_op_s    = OP_CAM;
        img_addr_s  = '0;
        img_bank_s  = cam_key_s;
        img_in_s    = cam_vec_s;
      end
      default: begin
        img_valid_s = 1'b0;
        img_op_s    = OP_IDLE;
      end
    endcase
  end

  // Bus only changes on start, on acceptance or on abort, so a stalled command stays put.
  always_comb begin
    cmd_valid_d = cmd_valid_q;
    op_d        = op_q;
    addr_d      = addr_q;
    data_bank_d = data_bank_q;
    data_in_d   = data_in_q;
    if (abort) begin
      cmd_valid_d = 1'b0;
      op_d        = OP_IDLE;
    end else if (load_s) begin
      cmd_valid_d = img_valid_s;
      op_d        = img_op_s;
      addr_d      = img_addr_s;
      data_bank_d = img_bank_s;
      data_in_d   = img_in_s;
    end else begin
      cmd_valid_d = cmd_valid_q;
      op_d        = op_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_valid_q <= 1'b0;
      op_q        <= OP_IDLE;
      addr_q      <= '0;
      data_bank_q <= '0;
      data_in_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      data_bank_q <= data_bank_d;
      data_in_q   <= data_in_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_mac_q  <= 1'b0;
      en_cam_q  <= 1'b0;
      seed_q    <= '0;
      mac_vec_q <= '0;
      cam_key_q <= '0;
      cam_vec_q <= '0;
    end else if (cfg_load_s) begin
      en_mac_q  <= en_mac;
      en_cam_q  <= en_cam;
      seed_q    <= seed;
      mac_vec_q <= mac_vec;
      cam_key_q <= cam_key;
      cam_vec_q <= cam_vec;
    end else begin
      en_mac_q  <= en_mac_q;
      en_cam_q  <= en_cam_q;
      seed_q    <= seed_q;
      mac_vec_q <= mac_vec_q;
      cam_key_q <= cam_key_q;
      cam_vec_q <= cam_vec_q;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign op_code   = op_q;
  assign addr      = addr_q;
  assign data_bank = data_bank_q;
  assign data_in   = data_in_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
